// File: rtl/rv2t_mem_arbiter.sv
// rv2t_mem_arbiter: shares the single memory controller port between the
// instruction fetch unit and the load/store unit, one transaction at a time,
// with round-robin tie-break and a watchdog on mem_done.
module rv2t_mem_arbiter #(
  parameter int unsigned PC_BITWIDTH = 24,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sync_reset,
  input  logic                   fetch_read_enable,
  input  logic [PC_BITWIDTH-1:0] fetch_read_addr,
  output logic                   fetch_read_done,
  output logic [XLEN-1:0]        fetch_data,
  input  logic                   data_read_enable,
  input  logic                   data_write_enable,
  input  logic [PC_BITWIDTH-1:0] data_addr,
  input  logic [XLEN-1:0]        data_write_data,
  input  logic [3:0]             data_byte_enable,
  output logic                   data_done,
  output logic [XLEN-1:0]        data_read_data,
  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  output logic [PC_BITWIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]        mem_write_data,
  output logic [3:0]             mem_byte_enable,
  input  logic                   mem_done,
  input  logic [XLEN-1:0]        mem_read_data,
  output logic                   timeout_error,
  output logic                   overflow_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // Last counter value before the watchdog fires; the abort is visible
  // TIMEOUT cycles after the command cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_FETCH = 3'b010,
    S_DATA  = 3'b100
  } state_e;

  typedef struct packed {
    logic [PC_BITWIDTH-1:0] addr;
    logic [XLEN-1:0]        wdata;
    logic [3:0]             be;
    logic                   write;
  } data_req_t;

  state_e                 state_q, state_d;
  logic                   last_data_q, last_data_d;
  logic                   fetch_pend_q, fetch_pend_d;
  logic                   data_pend_q, data_pend_d;
  logic [PC_BITWIDTH-1:0] fetch_addr_q, fetch_addr_d;
  data_req_t              data_req_q, data_req_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   fetch_done_q, fetch_done_d;
  logic [XLEN-1:0]        fetch_rdata_q, fetch_rdata_d;
  logic                   data_done_q, data_done_d;
  logic [XLEN-1:0]        data_rdata_q, data_rdata_d;
  logic                   mem_re_q, mem_re_d;
  logic                   mem_we_q, mem_we_d;
  logic [PC_BITWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic                   timeout_q, timeout_d;

  logic                   data_pulse, fetch_accept, data_accept;
  logic                   fetch_eff, data_eff;
  logic [PC_BITWIDTH-1:0] fetch_sel_addr;
  data_req_t              data_in, data_sel;

  // Request capture, arbitration, command issue and completion routing
  always_comb begin
    state_d       = state_q;
    last_data_d   = last_data_q;
    fetch_pend_d  = fetch_pend_q;
    data_pend_d   = data_pend_q;
    fetch_addr_d  = fetch_addr_q;
    data_req_d    = data_req_q;
    cnt_d         = '0;
    fetch_done_d  = 1'b0;
    fetch_rdata_d = '0;
    data_done_d   = 1'b0;
    data_rdata_d  = '0;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    mem_be_d      = '0;
    timeout_d     = 1'b0;

    data_pulse       = data_read_enable | data_write_enable;
    data_in.addr     = data_addr;
    data_in.wdata    = data_write_data;
    data_in.be       = data_byte_enable;
    data_in.write    = data_write_enable;

    // A pulse is taken only if its side is neither pending nor in service
    fetch_accept = fetch_read_enable && !fetch_pend_q && (state_q != S_FETCH);
    data_accept  = data_pulse && !data_pend_q && (state_q != S_DATA);
    overflow_d   = overflow_q | (fetch_read_enable & ~fetch_accept)
                              | (data_pulse & ~data_accept);

    if (fetch_accept) begin
      fetch_pend_d = 1'b1;
      fetch_addr_d = fetch_read_addr;
    end
    if (data_accept) begin
      data_pend_d = 1'b1;
      data_req_d  = data_in;
    end

    // Pending fields win over a same-cycle (overflowing) pulse
    fetch_eff      = fetch_read_enable | fetch_pend_q;
    data_eff       = data_pulse | data_pend_q;
    fetch_sel_addr = fetch_pend_q ? fetch_addr_q : fetch_read_addr;
    data_sel       = data_pend_q ? data_req_q : data_in;

    case (state_q)
      S_IDLE: begin
        if (fetch_eff && (!data_eff || last_data_q)) begin
          state_d      = S_FETCH;
          last_data_d  = 1'b0;
          fetch_pend_d = 1'b0;
          mem_re_d     = 1'b1;
          mem_addr_d   = fetch_sel_addr;
        end else if (data_eff) begin
          state_d     = S_DATA;
          last_data_d = 1'b1;
          data_pend_d = 1'b0;
          mem_addr_d  = data_sel.addr;
          if (data_sel.write) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = data_sel.wdata;
            mem_be_d    = data_sel.be;
          end else begin
            mem_re_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (mem_done) begin
          state_d       = S_IDLE;
          fetch_done_d  = 1'b1;
          fetch_rdata_d = mem_read_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          fetch_done_d = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (mem_done) begin
          state_d      = S_IDLE;
          data_done_d  = 1'b1;
          data_rdata_d = data_req_q.write ? '0 : mem_read_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          data_done_d = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sync_reset) begin
      state_d       = S_IDLE;
      last_data_d   = 1'b1;
      fetch_pend_d  = 1'b0;
      data_pend_d   = 1'b0;
      fetch_addr_d  = '0;
      data_req_d    = '0;
      cnt_d         = '0;
      overflow_d    = 1'b0;
      fetch_done_d  = 1'b0;
      fetch_rdata_d = '0;
      data_done_d   = 1'b0;
      data_rdata_d  = '0;
      mem_re_d      = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = '0;
      mem_wdata_d   = '0;
      mem_be_d      = '0;
      timeout_d     = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_data_q   <= 1'b1;
      fetch_pend_q  <= 1'b0;
      data_pend_q   <= 1'b0;
      fetch_addr_q  <= '0;
      data_req_q    <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_rdata_q <= '0;
      data_done_q   <= 1'b0;
      data_rdata_q  <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_data_q   <= last_data_d;
      fetch_pend_q  <= fetch_pend_d;
      data_pend_q   <= data_pend_d;
      fetch_addr_q  <= fetch_addr_d;
      data_req_q    <= data_req_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      fetch_done_q  <= fetch_done_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_done_q   <= data_done_d;
      data_rdata_q  <= data_rdata_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      timeout_q     <= timeout_d;
    end
  end

  assign fetch_read_done  = fetch_done_q;
  assign fetch_data       = fetch_rdata_q;
  assign data_done        = data_done_q;
  assign data_read_data   = data_rdata_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_byte_enable  = mem_be_q;
  assign timeout_error    = timeout_q;
  assign overflow_error   = overflow_q;

endmodule

// File: tb/tb_rv2t_mem_arbiter.sv
// Directed testbench for rv2t_mem_arbiter (TIMEOUT = 8).
module tb_rv2t_mem_arbiter;

  localparam int unsigned PC_W = 24;
  localparam int unsigned XW   = 32;

  logic            clk;
  logic            reset;
  logic            sync_reset;
  logic            fetch_read_enable;
  logic [PC_W-1:0] fetch_read_addr;
  logic            fetch_read_done;
  logic [XW-1:0]   fetch_data;
  logic            data_read_enable;
  logic            data_write_enable;
  logic [PC_W-1:0] data_addr;
  logic [XW-1:0]   data_write_data;
  logic [3:0]      data_byte_enable;
  logic            data_done;
  logic [XW-1:0]   data_read_data;
  logic            mem_read_enable;
  logic            mem_write_enable;
  logic [PC_W-1:0] mem_addr;
  logic [XW-1:0]   mem_write_data;
  logic [3:0]      mem_byte_enable;
  logic            mem_done;
  logic [XW-1:0]   mem_read_data;
  logic            timeout_error;
  logic            overflow_error;

  int errors = 0;
  int checks = 0;
  int fdone_cnt = 0;
  int both_cnt = 0;
  int fd0;

  rv2t_mem_arbiter #(.PC_BITWIDTH(PC_W), .XLEN(XW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .sync_reset(sync_reset),
    .fetch_read_enable(fetch_read_enable), .fetch_read_addr(fetch_read_addr),
    .fetch_read_done(fetch_read_done), .fetch_data(fetch_data),
    .data_read_enable(data_read_enable), .data_write_enable(data_write_enable),
    .data_addr(data_addr), .data_write_data(data_write_data),
    .data_byte_enable(data_byte_enable), .data_done(data_done),
    .data_read_data(data_read_data), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_done(mem_done), .mem_read_data(mem_read_data),
    .timeout_error(timeout_error), .overflow_error(overflow_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count fetch completions and any overlap of the two done pulses
  always @(negedge clk) begin
    if (fetch_read_done) fdone_cnt++;
    if (fetch_read_done && data_done) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_read_enable = 1'b0;
    fetch_read_addr   = '0;
    data_read_enable  = 1'b0;
    data_write_enable = 1'b0;
    data_addr         = '0;
    data_write_data   = '0;
    data_byte_enable  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    mem_done      = 1'b0;
    mem_read_data = '0;
    sync_reset    = 1'b0;
    reset         = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mre"},  64'(mem_read_enable), 64'd0);
    check({tag, "_mwe"},  64'(mem_write_enable), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_fdn"},  64'(fetch_read_done), 64'd0);
    check({tag, "_ddn"},  64'(data_done), 64'd0);
    check({tag, "_to"},   64'(timeout_error), 64'd0);
    check({tag, "_ovf"},  64'(overflow_error), 64'd0);
  endtask

  initial begin
    do_reset();
    check_all_zero("rst");

    // Single fetch: command next cycle, done the cycle after mem_done
    fetch_read_enable = 1'b1; fetch_read_addr = 24'h000100;
    step();
    clear_inputs();
    check("f1_mre", 64'(mem_read_enable), 64'd1);
    check("f1_addr", 64'(mem_addr), 64'h100);
    check("f1_mwe", 64'(mem_write_enable), 64'd0);
    check("f1_be", 64'(mem_byte_enable), 64'd0);
    step();
    check("f1_mre_once", 64'(mem_read_enable), 64'd0);
    step(2);
    mem_done = 1'b1; mem_read_data = 32'h00000013;
    step();
    mem_done = 1'b0;
    check("f1_done", 64'(fetch_read_done), 64'd1);
    check("f1_data", 64'(fetch_data), 64'h13);
    check("f1_ddone", 64'(data_done), 64'd0);
    step();
    check("f1_done_once", 64'(fetch_read_done), 64'd0);

    // Simultaneous fetch and write after reset: fetch first, then write
    do_reset();
    fetch_read_enable = 1'b1; fetch_read_addr = 24'h000200;
    data_write_enable = 1'b1; data_addr = 24'h001000;
    data_write_data = 32'hDEADBEEF; data_byte_enable = 4'hF;
    step();
    clear_inputs();
    check("sim_f_mre", 64'(mem_read_enable), 64'd1);
    check("sim_f_addr", 64'(mem_addr), 64'h200);
    check("sim_f_mwe", 64'(mem_write_enable), 64'd0);
    step(2);
    mem_done = 1'b1; mem_read_data = 32'h00000077;
    step();
    mem_done = 1'b0;
    check("sim_f_done", 64'(fetch_read_done), 64'd1);
    check("sim_f_data", 64'(fetch_data), 64'h77);
    check("sim_no_early_w", 64'(mem_write_enable), 64'd0);
    step();
    check("sim_w_mwe", 64'(mem_write_enable), 64'd1);
    check("sim_w_mre", 64'(mem_read_enable), 64'd0);
    check("sim_w_addr", 64'(mem_addr), 64'h1000);
    check("sim_w_wdata", 64'(mem_write_data), 64'hDEADBEEF);
    check("sim_w_be", 64'(mem_byte_enable), 64'hF);
    mem_done = 1'b1; mem_read_data = 32'h00005555;
    step();
    mem_done = 1'b0;
    check("sim_w_done", 64'(data_done), 64'd1);
    check("sim_w_rdata", 64'(data_read_data), 64'd0);
    check("sim_w_fdone", 64'(fetch_read_done), 64'd0);
    check("sim_ovf", 64'(overflow_error), 64'd0);
    step();

    // Round robin: both sides keep re-requesting; F first, then D,F,D,...
    fetch_read_enable = 1'b1; fetch_read_addr = 24'h000300;
    data_read_enable  = 1'b1; data_addr = 24'h002000;
    step();
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      logic exp_fetch;
      exp_fetch = ((i % 2) == 0);
      check($sformatf("rr%0d_mre", i), 64'(mem_read_enable), 64'd1);
      check($sformatf("rr%0d_owner", i), 64'(mem_addr), exp_fetch ? 64'h300 : 64'h2000);
      mem_done = 1'b1; mem_read_data = 32'(i + 16);
      step();
      mem_done = 1'b0;
      check($sformatf("rr%0d_fdone", i), 64'(fetch_read_done), 64'(exp_fetch));
      check($sformatf("rr%0d_ddone", i), 64'(data_done), 64'(!exp_fetch));
      if (exp_fetch) begin
        fetch_read_enable = 1'b1; fetch_read_addr = 24'h000300;
      end else begin
        check($sformatf("rr%0d_rdata", i), 64'(data_read_data), 64'(i + 16));
        data_read_enable = 1'b1; data_addr = 24'h002000;
      end
      step();
      clear_inputs();
    end
    // Drain the remaining fetch in service and the pending data read
    check("rr_tail_f", 64'(mem_addr), 64'h300);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    step();
    check("rr_tail_d", 64'(mem_addr), 64'h2000);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check("rr_tail_ddone", 64'(data_done), 64'd1);
    check("rr_ovf", 64'(overflow_error), 64'd0);
    step();

    // Timeout: mem_done withheld, abort 8 cycles after the command
    data_read_enable = 1'b1; data_addr = 24'h003000;
    step();
    clear_inputs();
    check("to_mre", 64'(mem_read_enable), 64'd1);
    step(7);
    check("to_early_done", 64'(data_done), 64'd0);
    check("to_early_err", 64'(timeout_error), 64'd0);
    step();
    check("to_done", 64'(data_done), 64'd1);
    check("to_err", 64'(timeout_error), 64'd1);
    check("to_rdata", 64'(data_read_data), 64'd0);
    step();
    check("to_err_once", 64'(timeout_error), 64'd0);
    mem_done = 1'b1; mem_read_data = 32'h00000099;
    step();
    mem_done = 1'b0;
    check("stray_ddone", 64'(data_done), 64'd0);
    check("stray_fdone", 64'(fetch_read_done), 64'd0);

    // mem_done on the last watchdog cycle: normal completion, no error
    data_read_enable = 1'b1; data_addr = 24'h003004;
    step();
    clear_inputs();
    step(7);
    mem_done = 1'b1; mem_read_data = 32'h00001234;
    step();
    mem_done = 1'b0;
    check("tob_done", 64'(data_done), 64'd1);
    check("tob_rdata", 64'(data_read_data), 64'h1234);
    check("tob_err", 64'(timeout_error), 64'd0);
    step();

    // Overflow: second fetch pulse while fetch is pending
    fd0 = fdone_cnt;
    data_read_enable = 1'b1; data_addr = 24'h004000;
    step();
    clear_inputs();
    check("ovf_d_addr", 64'(mem_addr), 64'h4000);
    fetch_read_enable = 1'b1; fetch_read_addr = 24'h000500;
    step();
    check("ovf_not_yet", 64'(overflow_error), 64'd0);
    fetch_read_addr = 24'h000600;
    step();
    clear_inputs();
    check("ovf_set", 64'(overflow_error), 64'd1);
    mem_done = 1'b1; mem_read_data = 32'h000000AA;
    step();
    mem_done = 1'b0;
    check("ovf_ddone", 64'(data_done), 64'd1);
    step();
    check("ovf_f_mre", 64'(mem_read_enable), 64'd1);
    check("ovf_f_addr", 64'(mem_addr), 64'h500);
    mem_done = 1'b1; mem_read_data = 32'h000000BB;
    step();
    mem_done = 1'b0;
    check("ovf_fdone", 64'(fetch_read_done), 64'd1);
    check("ovf_fdata", 64'(fetch_data), 64'hBB);
    step(3);
    check("ovf_one_fdone", 64'(fdone_cnt - fd0), 64'd1);
    check("ovf_no_cmd", 64'(mem_read_enable), 64'd0);
    check("ovf_sticky", 64'(overflow_error), 64'd1);

    // sync_reset mid-transaction with a data read pending
    fetch_read_enable = 1'b1; fetch_read_addr = 24'h000700;
    step();
    clear_inputs();
    check("sr_f_mre", 64'(mem_read_enable), 64'd1);
    data_read_enable = 1'b1; data_addr = 24'h005000;
    step();
    clear_inputs();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    check_all_zero("sr");
    mem_done = 1'b1; mem_read_data = 32'h00000042;
    step();
    mem_done = 1'b0;
    check("sr_no_fdone", 64'(fetch_read_done), 64'd0);
    check("sr_no_ddone", 64'(data_done), 64'd0);
    check("sr_pend_clr", 64'(mem_read_enable), 64'd0);
    fetch_read_enable = 1'b1; fetch_read_addr = 24'h000800;
    step();
    clear_inputs();
    check("sr_idle_mre", 64'(mem_read_enable), 64'd1);
    check("sr_idle_addr", 64'(mem_addr), 64'h800);
    mem_done = 1'b1; mem_read_data = 32'h00000001;
    step();
    mem_done = 1'b0;
    check("sr_fdone", 64'(fetch_read_done), 64'd1);
    step(2);

    check("done_exclusive", 64'(both_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
